// File: rtl/arbiter_pkg.sv
// Shared types for the two-to-one Avalon-MM port arbiter.
// Requester encoding doubles as the owner tag stored for each outstanding read.
package arbiter_pkg;

  typedef enum logic {
    REQ_INSTR = 1'b0,
    REQ_DATA  = 1'b1
  } requester_t;

  localparam logic [3:0] FULL_BYTEENABLE = 4'b1111;

  function automatic requester_t other_requester(input requester_t r);
    return (r == REQ_INSTR) ? REQ_DATA : REQ_INSTR;
  endfunction

endpackage

// File: rtl/owner_fifo.sv
// Small FIFO of requester tags, one entry per outstanding read.
// Push beyond full and pop from empty are ignored; the arbiter guards both.
module owner_fifo
  import arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  requester_t    push_owner,
  input  logic          pop,
  output requester_t    head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  requester_t    slots [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = slots[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; count gates every read of it.
  always_ff @(posedge clock) begin
    if (do_push) slots[wr_ptr] <= push_owner;
  end

endmodule

// File: rtl/avalon_shared_port_arbiter.sv
// Two-to-one Avalon-MM arbiter sharing one memory master between the clarvi
// instruction and data ports, with in-order routing of pipelined read responses.
module avalon_shared_port_arbiter
  import arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 29,
  parameter int MAX_PENDING = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [ADDR_WIDTH-1:0]        instr_address,
  input  logic                         instr_read,
  output logic                         instr_waitrequest,
  output logic [31:0]                  instr_readdata,
  output logic                         instr_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]        data_address,
  input  logic [3:0]                   data_byteenable,
  input  logic                         data_read,
  input  logic                         data_write,
  input  logic [31:0]                  data_writedata,
  output logic                         data_waitrequest,
  output logic [31:0]                  data_readdata,
  output logic                         data_readdatavalid,
  output logic [ADDR_WIDTH-1:0]        mem_address,
  output logic [3:0]                   mem_byteenable,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [31:0]                  mem_writedata,
  input  logic [31:0]                  mem_readdata,
  input  logic                         mem_waitrequest,
  input  logic                         mem_readdatavalid,
  output logic [$clog2(MAX_PENDING):0] pending_count,
  output logic                         protocol_error
);

  requester_t rr_next;
  requester_t lock_owner;
  requester_t grant;
  requester_t fifo_head;
  logic       locked;
  logic       fifo_full;
  logic       fifo_empty;
  logic       data_req;
  logic       granted_read;
  logic       granted_write;
  logic       fwd_read;
  logic       fwd_write;
  logic       accept;
  logic       granted_wait;
  logic       rsp_valid;

  assign data_req = data_read || data_write;

  // NOTE: grant is assigned a default before the branches so no latch is inferred.
  always_comb begin
    grant = rr_next;
    if (locked)                      grant = lock_owner;
    else if (instr_read && !data_req) grant = REQ_INSTR;
    else if (!instr_read && data_req) grant = REQ_DATA;
  end

  assign granted_read  = (grant == REQ_INSTR) ? instr_read : data_read;
  assign granted_write = (grant == REQ_DATA) && data_write;

  // Registered full flag: a pop in this cycle only frees a slot from the next one.
  assign fwd_read  = reset && granted_read && !fifo_full;
  assign fwd_write = reset && granted_write;
  assign accept    = (fwd_read || fwd_write) && !mem_waitrequest;

  assign mem_address    = (grant == REQ_INSTR) ? instr_address : data_address;
  assign mem_byteenable = (grant == REQ_INSTR) ? FULL_BYTEENABLE : data_byteenable;
  assign mem_writedata  = data_writedata;
  assign mem_read       = fwd_read;
  assign mem_write      = fwd_write;

  assign granted_wait      = !reset || (granted_read && fifo_full) || mem_waitrequest;
  assign instr_waitrequest = (grant == REQ_INSTR) ? granted_wait : 1'b1;
  assign data_waitrequest  = (grant == REQ_DATA)  ? granted_wait : 1'b1;

  assign rsp_valid           = reset && mem_readdatavalid && !fifo_empty;
  assign instr_readdatavalid = rsp_valid && (fifo_head == REQ_INSTR);
  assign data_readdatavalid  = rsp_valid && (fifo_head == REQ_DATA);
  assign instr_readdata      = mem_readdata;
  assign data_readdata       = mem_readdata;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_next        <= REQ_INSTR;
      locked         <= 1'b0;
      lock_owner     <= REQ_INSTR;
      protocol_error <= 1'b0;
    end else begin
      if (accept) begin
        locked  <= 1'b0;
        rr_next <= other_requester(grant);
      end else if (fwd_read || fwd_write) begin
        // Hold the stalled command on the bus until the slave takes it.
        locked     <= 1'b1;
        lock_owner <= grant;
      end
      if (mem_readdatavalid && fifo_empty) protocol_error <= 1'b1;
    end
  end

  owner_fifo #(
    .DEPTH(MAX_PENDING)
  ) u_owner_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (accept && fwd_read),
    .push_owner (grant),
    .pop        (mem_readdatavalid),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (pending_count)
  );

endmodule

// File: tb/tb_avalon_shared_port_arbiter.sv
// Directed bench for avalon_shared_port_arbiter with a behavioural memory and
// per-port scoreboards of expected read data.
module tb_avalon_shared_port_arbiter;
  import arbiter_pkg::*;

  localparam int AW = 29;
  localparam int MP = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] instr_address;
  logic          instr_read;
  logic          instr_waitrequest;
  logic [31:0]   instr_readdata;
  logic          instr_readdatavalid;
  logic [AW-1:0] data_address;
  logic [3:0]    data_byteenable;
  logic          data_read;
  logic          data_write;
  logic [31:0]   data_writedata;
  logic          data_waitrequest;
  logic [31:0]   data_readdata;
  logic          data_readdatavalid;
  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byteenable;
  logic          mem_read;
  logic          mem_write;
  logic [31:0]   mem_writedata;
  logic [31:0]   mem_readdata = '0;
  logic          mem_waitrequest;
  logic          mem_readdatavalid = 1'b0;
  logic [$clog2(MP):0] pending_count;
  logic          protocol_error;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int latency = 2;
  bit hold = 1'b0;
  int instr_rdv_cyc = -1;
  int data_rdv_cyc  = -1;

  logic [31:0] iq[$];
  logic [31:0] dq[$];
  logic [31:0] resp_q[$];
  int          due_q[$];

  always #5 clock = ~clock;

  avalon_shared_port_arbiter #(.ADDR_WIDTH(AW), .MAX_PENDING(MP)) dut (
    .clock               (clock),
    .reset               (reset),
    .instr_address       (instr_address),
    .instr_read          (instr_read),
    .instr_waitrequest   (instr_waitrequest),
    .instr_readdata      (instr_readdata),
    .instr_readdatavalid (instr_readdatavalid),
    .data_address        (data_address),
    .data_byteenable     (data_byteenable),
    .data_read           (data_read),
    .data_write          (data_write),
    .data_writedata      (data_writedata),
    .data_waitrequest    (data_waitrequest),
    .data_readdata       (data_readdata),
    .data_readdatavalid  (data_readdatavalid),
    .mem_address         (mem_address),
    .mem_byteenable      (mem_byteenable),
    .mem_read            (mem_read),
    .mem_write           (mem_write),
    .mem_writedata       (mem_writedata),
    .mem_readdata        (mem_readdata),
    .mem_waitrequest     (mem_waitrequest),
    .mem_readdatavalid   (mem_readdatavalid),
    .pending_count       (pending_count),
    .protocol_error      (protocol_error)
  );

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory: accepted reads answer in order, `latency` edges later, unless held.
  always @(negedge clock) begin
    if (mem_read && !mem_waitrequest) begin
      resp_q.push_back(mem_word(mem_address));
      due_q.push_back(cyc + latency);
    end
  end

  always @(posedge clock) begin
    cyc++;
    #1;
    if (!hold && due_q.size() > 0 && due_q[0] <= cyc) begin
      mem_readdata      = resp_q.pop_front();
      void'(due_q.pop_front());
      mem_readdatavalid = 1'b1;
    end else begin
      mem_readdatavalid = 1'b0;
    end
  end

  always @(negedge clock) begin
    if (instr_readdatavalid) begin
      instr_rdv_cyc = cyc;
      if (iq.size() == 0) check("instr_rdv_spurious", 32'd1, 32'd0);
      else check("instr_readdata", instr_readdata, iq.pop_front());
    end
    if (data_readdatavalid) begin
      data_rdv_cyc = cyc;
      if (dq.size() == 0) check("data_rdv_spurious", 32'd1, 32'd0);
      else check("data_readdata", data_readdata, dq.pop_front());
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((iq.size() != 0 || dq.size() != 0 || resp_q.size() != 0 || mem_readdatavalid) && n < 40) begin
      step();
      n++;
    end
    check("drain_left", 32'(iq.size() + dq.size() + resp_q.size()), 32'd0);
    check("drain_pending", 32'(pending_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    requester_t exp_g;
    int n_i;
    int n_d;

    reset = 1'b0;
    instr_address = '0;  instr_read = 1'b1;
    data_address = '0;   data_byteenable = 4'h0;
    data_read = 1'b0;    data_write = 1'b1;
    data_writedata = '0; mem_waitrequest = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_instr_wait", 32'(instr_waitrequest), 32'd1);
    check("rst_data_wait", 32'(data_waitrequest), 32'd1);
    check("rst_pending", 32'(pending_count), 32'd0);
    check("rst_perr", 32'(protocol_error), 32'd0);
    check("rst_rdv", 32'({instr_readdatavalid, data_readdatavalid}), 32'd0);
    step();
    reset = 1'b1;
    instr_read = 1'b0;
    data_write = 1'b0;

    // Single data write passes straight through.
    data_write = 1'b1; data_address = 29'h100;
    data_writedata = 32'hDEADBEEF; data_byteenable = 4'hF;
    @(negedge clock);
    check("wr_mem_write", 32'(mem_write), 32'd1);
    check("wr_mem_read", 32'(mem_read), 32'd0);
    check("wr_address", 32'(mem_address), 32'h100);
    check("wr_data", mem_writedata, 32'hDEADBEEF);
    check("wr_be", 32'(mem_byteenable), 32'hF);
    check("wr_data_wait", 32'(data_waitrequest), 32'd0);
    check("wr_instr_wait", 32'(instr_waitrequest), 32'd1);
    step();
    data_write = 1'b0;

    // Simultaneous reads: instr first, data on the next cycle.
    instr_read = 1'b1; instr_address = 29'h10; iq.push_back(mem_word(29'h10));
    data_read  = 1'b1; data_address  = 29'h20; dq.push_back(mem_word(29'h20));
    @(negedge clock);
    check("both_instr_wait", 32'(instr_waitrequest), 32'd0);
    check("both_data_wait", 32'(data_waitrequest), 32'd1);
    check("both_addr0", 32'(mem_address), 32'h10);
    check("both_be", 32'(mem_byteenable), 32'hF);
    step();
    instr_read = 1'b0;
    @(negedge clock);
    check("both_data_wait2", 32'(data_waitrequest), 32'd0);
    check("both_addr1", 32'(mem_address), 32'h20);
    step();
    data_read = 1'b0;
    drain();
    check("rdv_order", 32'(instr_rdv_cyc < data_rdv_cyc), 32'd1);

    // Lock: instr stalled by the slave keeps the bus although data has priority.
    instr_read = 1'b1; instr_address = 29'h28; iq.push_back(mem_word(29'h28));
    step();
    instr_read = 1'b0;
    mem_waitrequest = 1'b1;
    instr_read = 1'b1; instr_address = 29'h30; iq.push_back(mem_word(29'h30));
    @(negedge clock);
    check("lock_addr0", 32'(mem_address), 32'h30);
    check("lock_mem_read", 32'(mem_read), 32'd1);
    step();
    data_read = 1'b1; data_address = 29'h40; dq.push_back(mem_word(29'h40));
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("lock_addr_hold", 32'(mem_address), 32'h30);
      check("lock_instr_wait", 32'(instr_waitrequest), 32'd1);
      check("lock_data_wait", 32'(data_waitrequest), 32'd1);
      step();
    end
    mem_waitrequest = 1'b0;
    @(negedge clock);
    check("lock_accept_addr", 32'(mem_address), 32'h30);
    check("lock_accept_wait", 32'(instr_waitrequest), 32'd0);
    step();
    instr_read = 1'b0;
    @(negedge clock);
    check("lock_next_addr", 32'(mem_address), 32'h40);
    check("lock_next_wait", 32'(data_waitrequest), 32'd0);
    step();
    data_read = 1'b0;
    drain();

    // Full stall: four reads outstanding, fifth waits until one response has popped.
    hold = 1'b1;
    for (int i = 0; i < MP; i++) begin
      instr_read = 1'b1; instr_address = AW'(29'h50 + i);
      iq.push_back(mem_word(AW'(29'h50 + i)));
      @(negedge clock);
      check("fill_wait", 32'(instr_waitrequest), 32'd0);
      step();
    end
    instr_address = 29'h54; iq.push_back(mem_word(29'h54));
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("full_pending", 32'(pending_count), 32'd4);
      check("full_wait", 32'(instr_waitrequest), 32'd1);
      check("full_mem_read", 32'(mem_read), 32'd0);
      if (i == 0) step();
    end
    hold = 1'b0;
    step();
    @(negedge clock);
    check("pop_rdv", 32'(instr_readdatavalid), 32'd1);
    check("pop_still_wait", 32'(instr_waitrequest), 32'd1);
    check("pop_still_noread", 32'(mem_read), 32'd0);
    step();
    @(negedge clock);
    check("relief_wait", 32'(instr_waitrequest), 32'd0);
    check("relief_mem_read", 32'(mem_read), 32'd1);
    check("relief_addr", 32'(mem_address), 32'h54);
    step();
    instr_read = 1'b0;
    drain();

    // Reset with two reads outstanding; their late responses are unmatched.
    hold = 1'b1;
    instr_read = 1'b1; instr_address = 29'h70;
    step();
    instr_address = 29'h71;
    step();
    instr_read = 1'b0;
    @(negedge clock);
    check("pre_rst_pending", 32'(pending_count), 32'd2);
    step();
    reset = 1'b0;
    #1;
    check("mid_rst_pending", 32'(pending_count), 32'd0);
    check("mid_rst_wait", 32'({instr_waitrequest, data_waitrequest}), 32'd3);
    step();
    reset = 1'b1;
    @(negedge clock);
    hold = 1'b0;
    step();
    @(negedge clock);
    check("late_rdv_mem", 32'(mem_readdatavalid), 32'd1);
    check("late_port_rdv", 32'({instr_readdatavalid, data_readdatavalid}), 32'd0);
    check("late_perr_before", 32'(protocol_error), 32'd0);
    step();
    check("late_perr", 32'(protocol_error), 32'd1);
    drain();
    check("perr_sticky", 32'(protocol_error), 32'd1);

    // Continuous requests from both ports alternate strictly.
    exp_g = REQ_INSTR;
    n_i = 0;
    n_d = 0;
    instr_read = 1'b1; instr_address = 29'h80;
    data_write = 1'b1; data_address  = 29'h200; data_writedata = 32'h1234_5678;
    for (int c = 0; c < 20; c++) begin
      if (exp_g == REQ_INSTR) iq.push_back(mem_word(instr_address));
      @(negedge clock);
      check("alt_instr_wait", 32'(instr_waitrequest), 32'(exp_g != REQ_INSTR));
      check("alt_data_wait", 32'(data_waitrequest), 32'(exp_g != REQ_DATA));
      if (!instr_waitrequest) n_i++;
      if (!data_waitrequest)  n_d++;
      step();
      if (exp_g == REQ_INSTR) instr_address = instr_address + 1'b1;
      exp_g = other_requester(exp_g);
    end
    instr_read = 1'b0;
    data_write = 1'b0;
    check("alt_instr_count", 32'(n_i), 32'd10);
    check("alt_data_count", 32'(n_d), 32'd10);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/avalon_shared_port_arbiter.md
# avalon_shared_port_arbiter

Two-to-one Avalon-MM arbiter that lets the clarvi instruction port and data port share a single memory/interconnect master port, e.g. a single-port BRAM or one external SDRAM bridge. Pipelined reads are supported: an owner FIFO records which requester issued each outstanding read, so in-order `readdatavalid` responses are routed back correctly. Sits between `clarvi_avalon` and the shared memory in the top-level and simulation wrapper.

## Interface
- ADDR_WIDTH, 29, word-address width of all three ports
- MAX_PENDING, 4, maximum outstanding reads; power of two, 1..16

- clock  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- instr_address  in  ADDR_WIDTH  instruction-port word address
- instr_read  in  1  instruction read request
- instr_waitrequest  out  1  stall to instruction master
- instr_readdata  out  32  read data to instruction master
- instr_readdatavalid  out  1  read response valid, instruction port
- data_address  in  ADDR_WIDTH  data-port word address
- data_byteenable  in  4  byte lanes
- data_read / data_write  in  1 each  data requests; never both high
- data_writedata  in  32  write data
- data_waitrequest  out  1  stall to data master
- data_readdata  out  32  read data to data master
- data_readdatavalid  out  1  read response valid, data port
- mem_address  out  ADDR_WIDTH; mem_byteenable out 4; mem_read, mem_write out 1; mem_writedata out 32
- mem_readdata  in  32; mem_waitrequest in 1; mem_readdatavalid in 1
- pending_count  out  $clog2(MAX_PENDING)+1  outstanding reads
- protocol_error  out  1  sticky; set on `mem_readdatavalid` with no read outstanding

## Operation
- Requester index: 0 = instr, 1 = data. Registered state: `rr_next` (priority), `locked`, `lock_owner`, owner FIFO, `protocol_error`.
- Grant (combinational):
  - if `locked`, grant = `lock_owner`;
  - else the single requester present;
  - if both request, grant = `rr_next`.
- Granted command is forwarded to `mem_*`. Granted port's waitrequest = `mem_waitrequest`. The other port's waitrequest = 1. `instr_read` drives `mem_byteenable` = 4'b1111, `mem_write` = 0.
- Read stall: while pending_count == MAX_PENDING, a granted read is not forwarded (`mem_read` = 0) and the granted waitrequest = 1. Writes still proceed.
- Lock: a forwarded command with `mem_waitrequest` = 1 sets `locked` and `lock_owner` = grant. This keeps the command stable per Avalon rules.
- Acceptance (forwarded command and `mem_waitrequest` = 0):
  - clears `locked`;
  - sets `rr_next` = ~grant;
  - for a read, pushes grant into the owner FIFO.
- Response: `mem_readdatavalid` = 1 pops the FIFO head. The head owner's readdatavalid is driven high and `mem_readdata` is routed to both readdata outputs.
- Push and pop in the same cycle leave pending_count unchanged. A pop does not relieve a full-stall in the same cycle.
- `mem_readdatavalid` with the FIFO empty: the response is dropped, no port readdatavalid is asserted, and `protocol_error` is set until reset.

## Timing
- Reset values: `rr_next` = 0 (instr first), `locked` = 0, FIFO empty, pending_count = 0, `protocol_error` = 0.
- While reset is asserted:
  - `mem_read` = 0 and `mem_write` = 0;
  - both waitrequests = 1;
  - both readdatavalids = 0.
- Zero added latency: request to `mem_*` and `mem_readdatavalid` to port are combinational. One accepted command per cycle maximum.
- Reset asserted mid-transaction discards outstanding reads. Late `mem_readdatavalid` after reset release with an empty FIFO sets `protocol_error`.
- pending_count is registered and updates on the edge after accept/pop.

## Structure
- Package `arbiter_pkg`: `typedef enum logic {REQ_INSTR, REQ_DATA} requester_t`; constant `FULL_BYTEENABLE = 4'b1111`.
- Sub-module `owner_fifo`: parameterised width-1 FIFO of `requester_t`, depth MAX_PENDING, with push/pop/full/empty/count. The arbiter top holds grant, lock and round-robin logic.

## Test plan
- Both idle, then `data_write` to address 0x100 with data 0xDEADBEEF, `mem_waitrequest` = 0 -> same-cycle `mem_write` = 1 with matching address and data; `data_waitrequest` = 0; `instr_waitrequest` = 1.
- `instr_read` and `data_read` asserted together, memory latency 2 -> instr accepted first, data next cycle. `instr_readdatavalid` arrives before `data_readdatavalid`, each carrying its own word.
- Granted instr read with `mem_waitrequest` = 1 for 3 cycles while `data_read` arrives -> grant stays instr and `mem_address` is stable. Data is granted on the cycle after acceptance.
- MAX_PENDING = 4, memory holds readdatavalid low -> 4 reads accepted. The 5th read sees waitrequest = 1 and `mem_read` = 0. It is accepted one cycle after the first response.
- Reset asserted with 2 reads pending -> pending_count = 0 immediately. After release, an unmatched `mem_readdatavalid` -> `protocol_error` = 1, no port readdatavalid.
- Alternating continuous requests from both ports for 20 cycles -> grants strictly alternate, 10 accepted per port.
